// File: rtl/tx_beam_sequencer.sv
// tx_beam_sequencer: multi-channel delayed pulse sequencer with T/R switch settle guards and burst shots
module tx_beam_sequencer #(
  parameter int NUM_CH     = 8,
  parameter int PULSE_LEN  = 32,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int BURST_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_delays,
  input  logic [NUM_CH*CNT_W-1:0]   delays_flat,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [PULSE_LEN-1:0]      pulse_shape,
  input  logic                      start_transmit,
  input  logic [BURST_W-1:0]        burst_count,
  input  logic                      abort,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      switch,
  output logic [NUM_CH-1:0]         ultrasound_pulses,
  output logic [NUM_CH-1:0]         pulse_sent
);
  localparam int CW = CNT_W + 8;
  localparam logic [2:0] IDLE = 3'd0, LOADED = 3'd1, SETTLE_ON = 3'd2, FIRE = 3'd3,
                         GAP = 3'd4, SETTLE_OFF = 3'd5, DONE = 3'd6;
  logic [2:0] state, ns;
  logic [NUM_CH*CNT_W-1:0] delays_r;
  logic [NUM_CH-1:0] en_r, pulse_n, sent_n;
  logic [PULSE_LEN-1:0] shape_r, sh;
  logic [BURST_W-1:0] shots;
  logic [7:0] sc;
  logic [CW-1:0] cyc, cyc_n, dd, k;
  logic ab_r, settle_end, all_sent, take_abort, take_load;
  assign settle_end = sc == 8'(SETTLE_CYC - 1);
  assign all_sent = &pulse_sent;
  assign take_abort = abort && (state == SETTLE_ON || state == FIRE || state == GAP);
  assign take_load = load_delays && (state == IDLE || state == LOADED);
  assign cyc_n = state == FIRE ? cyc + CW'(1) : '0;
  always_comb begin
    ns = state;
    case (state)
      IDLE:       ns = load_delays ? LOADED : IDLE;
      LOADED:     ns = load_delays ? LOADED : start_transmit ? SETTLE_ON : LOADED;
      SETTLE_ON:  ns = abort ? SETTLE_OFF : settle_end ? FIRE : SETTLE_ON;
      FIRE:       ns = abort ? SETTLE_OFF : !all_sent ? FIRE : shots > BURST_W'(1) ? GAP : SETTLE_OFF;
      GAP:        ns = abort ? SETTLE_OFF : FIRE;
      SETTLE_OFF: ns = !settle_end ? SETTLE_OFF : ab_r ? LOADED : DONE;
      DONE:       ns = LOADED;
      default:    ns = IDLE;
    endcase
  end
  // The counter is wide enough that cyc_n - delay wraps far above PULSE_LEN before the channel starts.
  always_comb begin
    pulse_n = '0;
    sent_n = '0;
    dd = '0;
    k = '0;
    sh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dd = CW'(delays_r[i*CNT_W +: CNT_W]);
      k = cyc_n - dd;
      sh = shape_r << k;
      pulse_n[i] = en_r[i] && k < CW'(PULSE_LEN) && sh[PULSE_LEN-1];
      sent_n[i] = !en_r[i] || cyc_n >= dd + CW'(PULSE_LEN);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      delays_r <= '0;
      en_r <= '0;
      shape_r <= '0;
      shots <= '0;
      sc <= '0;
      cyc <= '0;
      ab_r <= 1'b0;
      ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      switch <= 1'b0;
      ultrasound_pulses <= '0;
      pulse_sent <= '0;
    end else begin
      state <= ns;
      sc <= ns == state ? sc + 8'd1 : '0;
      cyc <= cyc_n;
      if (take_load) begin
        delays_r <= delays_flat;
        en_r <= ch_enable;
        shape_r <= pulse_shape;
      end
      if (state == LOADED && ns == SETTLE_ON)
        shots <= burst_count == '0 ? BURST_W'(1) : burst_count;
      else if (state == FIRE && ns == GAP)
        shots <= shots - BURST_W'(1);
      ab_r <= take_abort || (ab_r && ns != LOADED);
      ready <= ns == LOADED;
      busy <= ns == SETTLE_ON || ns == FIRE || ns == GAP || ns == SETTLE_OFF;
      done <= ns == DONE;
      aborted <= take_abort;
      switch <= ns == SETTLE_ON || ns == FIRE || ns == GAP;
      ultrasound_pulses <= ns == FIRE ? pulse_n : '0;
      pulse_sent <= ns == FIRE ? sent_n
                  : (ns == GAP || take_abort || (state == LOADED && ns == SETTLE_ON)) ? '0
                  : pulse_sent;
    end
  end
endmodule
